// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: turns decode class flags into phase-gated write strobes
// with memory wait states, multi-cycle MUL/DIV wait and precise exception/interrupt entry.
module mc_ctrl_fsm #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33,
  parameter int INT_EN  = 1,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       c_alu,
  input  logic       c_jump,
  input  logic       c_branch,
  input  logic       c_load,
  input  logic       c_store,
  input  logic       c_mdu,
  input  logic       c_eret,
  input  logic       c_exc,
  input  logic       mdu_is_div,
  input  logic       rf_wr_req,
  input  logic       branch_taken,
  input  logic [4:0] exc_cause_in,
  input  logic       int_req,
  output logic       pc_we,
  output logic       ir_we,
  output logic       rf_we,
  output logic       dm_re,
  output logic       dm_we,
  output logic       mdu_start,
  output logic       hilo_we,
  output logic       exc_entry,
  output logic       eret_pulse,
  output logic [4:0] exc_cause,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_MDU = 3'd5,
    S_EXC = 3'd6
  } state_t;

  localparam logic             INT_ON = (INT_EN != 0);
  localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       cause_q, cause_d;
  logic             alu_q, jump_q, branch_q, load_q, store_q, rf_q;
  logic             alu_d, jump_d, branch_d, load_d, store_d, rf_d;

  logic pc_we_s, ir_we_s, rf_we_s, dm_re_s, dm_we_s;
  logic mdu_start_s, hilo_we_s, exc_entry_s, eret_pulse_s, busy_s;

  // State, MDU countdown, latched decode flags and cause register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IF;
      cnt_q    <= '0;
      cause_q  <= 5'd0;
      alu_q    <= 1'b0;
      jump_q   <= 1'b0;
      branch_q <= 1'b0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      rf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      alu_q    <= alu_d;
      jump_q   <= jump_d;
      branch_q <= branch_d;
      load_q   <= load_d;
      store_q  <= store_d;
      rf_q     <= rf_d;
    end
  end

  // Next-state and latch-update logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    alu_d    = alu_q;
    jump_d   = jump_q;
    branch_d = branch_q;
    load_d   = load_q;
    store_d  = store_q;
    rf_d     = rf_q;
    case (state_q)
      S_IF: begin
        if (INT_ON && int_req) begin
          state_d = S_EXC;
          cause_d = 5'd0;
        end else if (imem_ready) begin
          state_d = S_ID;
        end else begin
          state_d = S_IF;
        end
      end
      S_ID: begin
        alu_d    = c_alu;
        jump_d   = c_jump;
        branch_d = c_branch;
        load_d   = c_load;
        store_d  = c_store;
        rf_d     = rf_wr_req;
        cause_d  = exc_cause_in;
        if (c_exc) begin
          state_d = S_EXC;
        end else if (c_eret) begin
          state_d = S_IF;
        end else if (c_mdu) begin
          cnt_d   = mdu_is_div ? DIV_M1 : MUL_M1;
          state_d = S_MDU;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (branch_q) begin
          state_d = S_IF;
        end else if (jump_q) begin
          state_d = rf_q ? S_WB : S_IF;
        end else if (load_q || store_q) begin
          state_d = S_MEM;
        end else if (alu_q) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = load_q ? S_WB : S_IF;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB:  state_d = S_IF;
      S_MDU: begin
        if (cnt_q == '0) begin
          state_d = S_IF;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_EXC:   state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // Strobe decode; ID strobes follow the live decode flags with c_exc > c_eret > c_mdu
  always_comb begin
    pc_we_s      = 1'b0;
    ir_we_s      = 1'b0;
    rf_we_s      = 1'b0;
    dm_re_s      = 1'b0;
    dm_we_s      = 1'b0;
    mdu_start_s  = 1'b0;
    hilo_we_s    = 1'b0;
    exc_entry_s  = 1'b0;
    eret_pulse_s = 1'b0;
    busy_s       = 1'b0;
    case (state_q)
      S_IF: begin
        ir_we_s = imem_ready && !(INT_ON && int_req);
        pc_we_s = imem_ready && !(INT_ON && int_req);
      end
      S_ID: begin
        eret_pulse_s = !c_exc && c_eret;
        pc_we_s      = !c_exc && c_eret;
        mdu_start_s  = !c_exc && !c_eret && c_mdu;
      end
      S_EX:  pc_we_s = branch_q ? branch_taken : jump_q;
      S_MEM: begin
        dm_re_s = load_q;
        dm_we_s = !load_q && store_q;
      end
      S_WB:  rf_we_s = rf_q;
      S_MDU: begin
        busy_s    = 1'b1;
        hilo_we_s = (cnt_q == '0);
        rf_we_s   = (cnt_q == '0) && rf_q;
      end
      S_EXC: begin
        exc_entry_s = 1'b1;
        pc_we_s     = 1'b1;
      end
      default: busy_s = 1'b0;
    endcase
  end

  // Reset forces every strobe low even while live handshakes are high
  assign pc_we      = rst_n & pc_we_s;
  assign ir_we      = rst_n & ir_we_s;
  assign rf_we      = rst_n & rf_we_s;
  assign dm_re      = rst_n & dm_re_s;
  assign dm_we      = rst_n & dm_we_s;
  assign mdu_start  = rst_n & mdu_start_s;
  assign hilo_we    = rst_n & hilo_we_s;
  assign exc_entry  = rst_n & exc_entry_s;
  assign eret_pulse = rst_n & eret_pulse_s;
  assign busy       = rst_n & busy_s;
  assign exc_cause  = rst_n ? cause_q : 5'd0;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle expected strobes queued as driven, popped and checked mid-cycle.
module tb_mc_ctrl_fsm;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 33;

  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
                         S_WB = 3'd4, S_MDU = 3'd5, S_EXC = 3'd6;
  localparam logic [9:0] NONE = 10'b00_0000_0000, PC  = 10'b10_0000_0000,
                         IR   = 10'b01_0000_0000, RF  = 10'b00_1000_0000,
                         DRE  = 10'b00_0100_0000, DWE = 10'b00_0010_0000,
                         MST  = 10'b00_0001_0000, HILO = 10'b00_0000_1000,
                         EXE  = 10'b00_0000_0100, ERT = 10'b00_0000_0010,
                         BSY  = 10'b00_0000_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, imem_ready, dmem_ready;
  logic       c_alu, c_jump, c_branch, c_load, c_store, c_mdu, c_eret, c_exc;
  logic       mdu_is_div, rf_wr_req, branch_taken, int_req;
  logic [4:0] exc_cause_in;
  logic       pc_we, ir_we, rf_we, dm_re, dm_we, mdu_start, hilo_we, exc_entry, eret_pulse, busy;
  logic [4:0] exc_cause;
  logic [2:0] state;

  mc_ctrl_fsm #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .INT_EN(1), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .c_alu(c_alu), .c_jump(c_jump), .c_branch(c_branch), .c_load(c_load),
    .c_store(c_store), .c_mdu(c_mdu), .c_eret(c_eret), .c_exc(c_exc),
    .mdu_is_div(mdu_is_div), .rf_wr_req(rf_wr_req), .branch_taken(branch_taken),
    .exc_cause_in(exc_cause_in), .int_req(int_req),
    .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we), .dm_re(dm_re), .dm_we(dm_we),
    .mdu_start(mdu_start), .hilo_we(hilo_we), .exc_entry(exc_entry),
    .eret_pulse(eret_pulse), .exc_cause(exc_cause), .busy(busy), .state(state)
  );

  logic [18:0] sb_q[$];
  int checks   = 0;
  int failures = 0;

  // {alu, jump, branch, load, store, mdu, eret, exc}
  task automatic set_cls(input logic [7:0] cls);
    {c_alu, c_jump, c_branch, c_load, c_store, c_mdu, c_eret, c_exc} = cls;
  endtask

  // Push the expectation, compare 2ns later, then advance to 1ns after the next rising edge.
  // The cause field is only compared when cc is set (exception entry or reset).
  task automatic cyc(input string tag, input logic [2:0] s, input logic [9:0] m,
                     input logic [4:0] c, input logic cc);
    logic [18:0] e;
    logic [17:0] o;
    sb_q.push_back({cc, s, m, c});
    #2;
    e = sb_q.pop_front();
    o = {state, pc_we, ir_we, rf_we, dm_re, dm_we, mdu_start, hilo_we,
         exc_entry, eret_pulse, busy, exc_cause};
    if (!e[18]) begin
      o[4:0] = 5'd0;
      e[4:0] = 5'd0;
    end
    checks++;
    assert (o === e[17:0]) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e[17:0]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; int_req = 1'b0;
    set_cls(8'h00); mdu_is_div = 1'b0; rf_wr_req = 1'b0; branch_taken = 1'b0;
    exc_cause_in = 5'd0;
    @(posedge clk); #1;
    cyc("reset_idle", S_IF, NONE, 5'd0, 1'b1);
    int_req = 1'b1;
    cyc("reset_int", S_IF, NONE, 5'd0, 1'b1);
    int_req = 1'b0;
    rst_n = 1'b1;

    // ALU with RF write: 0,1,2,4 then back to IF
    set_cls(8'h80); rf_wr_req = 1'b1;
    cyc("alu_if", S_IF, PC | IR, 5'd0, 1'b0);
    cyc("alu_id", S_ID, NONE, 5'd0, 1'b0);
    int_req = 1'b1;
    cyc("alu_ex", S_EX, NONE, 5'd0, 1'b0);
    cyc("alu_wb", S_WB, RF, 5'd0, 1'b0);
    int_req = 1'b0;

    // Load with two memory wait states
    set_cls(8'h10); rf_wr_req = 1'b1; dmem_ready = 1'b0;
    cyc("ld_if", S_IF, PC | IR, 5'd0, 1'b0);
    cyc("ld_id", S_ID, NONE, 5'd0, 1'b0);
    cyc("ld_ex", S_EX, NONE, 5'd0, 1'b0);
    cyc("ld_mem0", S_MEM, DRE, 5'd0, 1'b0);
    cyc("ld_mem1", S_MEM, DRE, 5'd0, 1'b0);
    dmem_ready = 1'b1;
    cyc("ld_mem2", S_MEM, DRE, 5'd0, 1'b0);
    cyc("ld_wb", S_WB, RF, 5'd0, 1'b0);

    // Store preceded by one instruction-fetch wait state
    set_cls(8'h08); rf_wr_req = 1'b0; imem_ready = 1'b0;
    cyc("st_ifwait", S_IF, NONE, 5'd0, 1'b0);
    imem_ready = 1'b1;
    cyc("st_if", S_IF, PC | IR, 5'd0, 1'b0);
    cyc("st_id", S_ID, NONE, 5'd0, 1'b0);
    cyc("st_ex", S_EX, NONE, 5'd0, 1'b0);
    cyc("st_mem", S_MEM, DWE, 5'd0, 1'b0);

    // Branch not taken, then taken
    set_cls(8'h20); branch_taken = 1'b0;
    cyc("bnt_if", S_IF, PC | IR, 5'd0, 1'b0);
    cyc("bnt_id", S_ID, NONE, 5'd0, 1'b0);
    cyc("bnt_ex", S_EX, NONE, 5'd0, 1'b0);
    branch_taken = 1'b1;
    cyc("bt_if", S_IF, PC | IR, 5'd0, 1'b0);
    cyc("bt_id", S_ID, NONE, 5'd0, 1'b0);
    cyc("bt_ex", S_EX, PC, 5'd0, 1'b0);
    branch_taken = 1'b0;

    // jal: jump with link write
    set_cls(8'h40); rf_wr_req = 1'b1;
    cyc("jal_if", S_IF, PC | IR, 5'd0, 1'b0);
    cyc("jal_id", S_ID, NONE, 5'd0, 1'b0);
    cyc("jal_ex", S_EX, PC, 5'd0, 1'b0);
    cyc("jal_wb", S_WB, RF, 5'd0, 1'b0);

    // NOP: no class flag, rf_wr_req must be ignored
    set_cls(8'h00);
    cyc("nop_if", S_IF, PC | IR, 5'd0, 1'b0);
    cyc("nop_id", S_ID, NONE, 5'd0, 1'b0);
    cyc("nop_ex", S_EX, NONE, 5'd0, 1'b0);
    rf_wr_req = 1'b0;

    // eret (c_mdu also set: eret has priority)
    set_cls(8'h06);
    cyc("eret_if", S_IF, PC | IR, 5'd0, 1'b0);
    cyc("eret_id", S_ID, PC | ERT, 5'd0, 1'b0);

    // syscall with every lower-priority flag also set
    set_cls(8'hFF); exc_cause_in = 5'b01000;
    cyc("sys_if", S_IF, PC | IR, 5'd0, 1'b0);
    cyc("sys_id", S_ID, NONE, 5'd0, 1'b0);
    cyc("sys_exc", S_EXC, PC | EXE, 5'b01000, 1'b1);

    // Interrupt in IF beats a ready instruction word; cause 0
    set_cls(8'h80); exc_cause_in = 5'd0; int_req = 1'b1;
    cyc("int_if", S_IF, NONE, 5'd0, 1'b0);
    cyc("int_exc", S_EXC, PC | EXE, 5'd0, 1'b1);
    int_req = 1'b0;

    // div: 33 MDU cycles, hilo_we on the last, no RF write
    set_cls(8'h04); mdu_is_div = 1'b1; rf_wr_req = 1'b0;
    cyc("div_if", S_IF, PC | IR, 5'd0, 1'b0);
    cyc("div_id", S_ID, MST, 5'd0, 1'b0);
    for (int i = 0; i < DIV_LAT - 1; i++) cyc("div_busy", S_MDU, BSY, 5'd0, 1'b0);
    cyc("div_done", S_MDU, BSY | HILO, 5'd0, 1'b0);

    // mul: 4 MDU cycles, hilo_we and rf_we together
    mdu_is_div = 1'b0; rf_wr_req = 1'b1;
    cyc("mul_if", S_IF, PC | IR, 5'd0, 1'b0);
    cyc("mul_id", S_ID, MST, 5'd0, 1'b0);
    for (int i = 0; i < MUL_LAT - 1; i++) cyc("mul_busy", S_MDU, BSY, 5'd0, 1'b0);
    cyc("mul_done", S_MDU, BSY | HILO | RF, 5'd0, 1'b0);

    // div aborted by reset during MDU cycle 10
    mdu_is_div = 1'b1; rf_wr_req = 1'b0;
    cyc("abort_if", S_IF, PC | IR, 5'd0, 1'b0);
    cyc("abort_id", S_ID, MST, 5'd0, 1'b0);
    for (int i = 0; i < 9; i++) cyc("abort_busy", S_MDU, BSY, 5'd0, 1'b0);
    rst_n = 1'b0;
    cyc("abort_rst", S_IF, NONE, 5'd0, 1'b1);
    rst_n = 1'b1; imem_ready = 1'b0; set_cls(8'h00); mdu_is_div = 1'b0;
    for (int i = 0; i < DIV_LAT + 2; i++) cyc("abort_idle", S_IF, NONE, 5'd0, 1'b0);
    imem_ready = 1'b1; set_cls(8'h80); rf_wr_req = 1'b1;
    cyc("post_if", S_IF, PC | IR, 5'd0, 1'b0);
    cyc("post_id", S_ID, NONE, 5'd0, 1'b0);
    cyc("post_ex", S_EX, NONE, 5'd0, 1'b0);
    cyc("post_wb", S_WB, RF, 5'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle control sequencer for the 54-instruction MIPS core. It is the successor to the single-cycle combinational decoder. The datapath decode still supplies instruction-class flags, and this block turns them into phase-gated, single-cycle write strobes. It adds memory wait-state handshakes, a parametrised multi-cycle MUL/DIV wait with HI/LO writeback, and precise exception and interrupt entry. It sits between the instruction decode logic and the PC/IR/RF/DMEM/HI-LO/CP0 write enables.

Parameters:
MUL_LAT, 4, cycles spent in MDU state for mul/mult/multu (must be >=1)
DIV_LAT, 33, cycles spent in MDU state for div/divu (must be >=1)
INT_EN, 1, 1 = external interrupt sampling in IF enabled; 0 = int_req ignored
CNT_W, 6, MDU countdown width; must hold max(MUL_LAT,DIV_LAT)-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access completes this cycle
c_alu, c_jump, c_branch, c_load, c_store, c_mdu, c_eret, c_exc  in  1 each  class flags from decode; sampled in ID only
mdu_is_div  in  1  MDU op is div/divu; sampled in ID
rf_wr_req  in  1  instruction writes RF (incl. jal/jalr, mul); sampled in ID
branch_taken  in  1  branch condition; sampled in EX
exc_cause_in  in  5  cause code for c_exc; sampled in ID
int_req  in  1  level-sensitive external interrupt request
pc_we, ir_we, rf_we, dm_re, dm_we, mdu_start, hilo_we, exc_entry, eret_pulse  out  1 each  control strobes
exc_cause  out  5  cause register value, valid while exc_entry=1
busy  out  1  high while in MDU state
state  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4, MDU=5, EXC=6

Behaviour:
- Reset (async, rst_n=0): state=IF, MDU counter=0, latched flags=0, exc_cause=0. Every strobe, busy and exc_cause are 0 combinationally during reset.
- All outputs are Moore/Mealy combinational from state, latched flags and current handshakes. No strobe is ever asserted outside the states listed below.
- IF:
  - If INT_EN and int_req: go to EXC with latched cause 5'b00000. ir_we=0 and pc_we=0, even if imem_ready is high (interrupt wins).
  - Else if imem_ready: ir_we=1, pc_we=1 (PC+4 path), go to ID.
  - Else stay in IF.
- ID: latch the class flags, mdu_is_div, rf_wr_req and exc_cause_in. Priority is c_exc > c_eret > c_mdu > others.
  - c_exc: go to EXC.
  - c_eret: eret_pulse=1, pc_we=1, go to IF.
  - c_mdu: mdu_start=1 for this cycle only; load counter with (mdu_is_div ? DIV_LAT : MUL_LAT)-1; go to MDU.
  - Otherwise: go to EX.
  - If no class flag is set, treat the instruction as a NOP: go to EX, then IF, with no writes.
- EX:
  - branch: pc_we=branch_taken, go to IF.
  - jump: pc_we=1, then WB if rf_wr_req, else IF.
  - load/store: go to MEM.
  - alu: go to WB.
- MEM:
  - Load: dm_re=1 held every cycle until dmem_ready, then go to WB.
  - Store: dm_we=1 held until dmem_ready, then go to IF.
  - dm_we and dm_re are never both 1.
- WB: rf_we=latched rf_wr_req, go to IF.
- MDU:
  - busy=1; counter decrements each cycle.
  - On the cycle the counter is 0: hilo_we=1 and rf_we=latched rf_wr_req (mul writes the RF), then go to IF.
  - Total MDU residency is exactly LAT cycles.
- EXC: exc_entry=1, pc_we=1 (vector), exc_cause valid, go to IF. Exactly one cycle.
- Instruction cycle counts with zero wait states: branch/jump 3, alu 4, store 4, load 5, eret 2, exception 3, MDU 2+LAT. Each wait cycle in IF or MEM adds 1.
- int_req is ignored outside IF. An interrupt is never taken mid-instruction.
- Reset asserted mid-MDU or mid-MEM aborts immediately. After release, the FSM restarts in IF with the counter cleared and no pending strobes.
- Illegal state encodings (7) recover to IF on the next clock.

Test Plan:
- Reset then ALU op, imem_ready=1, rf_wr_req=1 -> state 0,1,2,4,0; ir_we at cycle 0, rf_we=1 only at cycle 3; 4 cycles total.
- Load with dmem_ready low for 2 cycles -> dm_re high 3 consecutive MEM cycles, dm_we never high, rf_we pulse in WB; 7 cycles total.
- div (mdu_is_div=1, DIV_LAT=33) -> mdu_start 1 cycle in ID; busy high 33 cycles; hilo_we on the 33rd MDU cycle; rf_we=0. mul with rf_wr_req=1 and MUL_LAT=4 -> hilo_we and rf_we together after 4 cycles.
- beq with branch_taken=0 -> pc_we only in IF. With branch_taken=1 -> pc_we in IF and EX.
- syscall (c_exc=1, exc_cause_in=5'b01000) -> EXC next cycle, exc_entry=1, pc_we=1, exc_cause=01000. int_req=1 in IF with imem_ready=1 -> no ir_we, EXC with cause 0.
- rst_n pulsed low during MDU cycle 10 -> busy=0 immediately; after release state=IF, no hilo_we ever issued.
